// File: rtl/branch_history_tracker.sv
// Speculative global-history tracker for a gshare predictor. It forms the PHT lookup index, carries predictions to Execute and repairs the GHR after a mispredict.
// Optional resolved/mispredicted branch counters are enabled by defining BHT_PERF_CNT_EN.
module branch_history_tracker #(
    parameter int INDEX_W = 3,
    parameter int HIST_W  = 3,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pcF,
    input  logic               branchF,
    input  logic               predictionF,
    input  logic               stallF,
    input  logic               stallD,
    input  logic               flushD,
    input  logic               flushE,
    input  logic               branchE,
    input  logic               branchTakenE,
    output logic [INDEX_W-1:0] PHTinpId,
    output logic [INDEX_W-1:0] PHTupdId,
    output logic               branchPredictedE,
    output logic               mispredictE,
    output logic [HIST_W-1:0]  ghrOut,
    output logic [31:0]        branchCount,
    output logic [31:0]        mispredictCount
);

    logic [HIST_W-1:0]  ghr;

    logic               validD, predD;
    logic [INDEX_W-1:0] idxD;
    logic [HIST_W-1:0]  ckptD;

    logic               validE, predE;
    logic [INDEX_W-1:0] idxE;
    logic [HIST_W-1:0]  ckptE;

    logic resolveE;
    logic fetchAcc;

    // Word-aligned PC bits and the GHR checkpoint MSB take no part in the logic.
    logic unusedBits;
    assign unusedBits = &{pcF[PC_W-1:INDEX_W+2], pcF[1:0], ckptE[HIST_W-1]};

    assign PHTinpId = pcF[INDEX_W+1:2] ^ INDEX_W'(ghr);
    assign ghrOut   = ghr;

    // NOTE: every output is given a default first, so no path through this block can infer a latch.
    always_comb begin
        resolveE         = validE && branchE;
        mispredictE      = 1'b0;
        branchPredictedE = 1'b0;
        PHTupdId         = idxE;
        if (resolveE) begin
            branchPredictedE = predE;
            mispredictE      = (branchTakenE != predE);
        end
    end

    // A branch fetched while Execute mispredicts is wrong-path and is dropped.
    assign fetchAcc = branchF && !stallF && !mispredictE;

    // NOTE: state registers use non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr <= '0;
        end else if (mispredictE) begin
            ghr <= {ckptE[HIST_W-2:0], branchTakenE};
        end else if (fetchAcc) begin
            ghr <= {ghr[HIST_W-2:0], predictionF};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validD <= 1'b0;
            idxD   <= '0;
            predD  <= 1'b0;
            ckptD  <= '0;
        end else if (mispredictE || flushD) begin
            validD <= 1'b0;
        end else if (stallD) begin
            validD <= validD;
        end else if (!stallF) begin
            validD <= fetchAcc;
            idxD   <= PHTinpId;
            predD  <= predictionF;
            ckptD  <= ghr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            validE <= 1'b0;
            idxE   <= '0;
            predE  <= 1'b0;
            ckptE  <= '0;
        end else if (mispredictE || flushE) begin
            validE <= 1'b0;
        end else begin
            validE <= validD;
            idxE   <= idxD;
            predE  <= predD;
            ckptE  <= ckptD;
        end
    end

`ifdef BHT_PERF_CNT_EN
    logic [31:0] branchCnt;
    logic [31:0] mispredictCnt;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            branchCnt     <= '0;
            mispredictCnt <= '0;
        end else begin
            if (resolveE && (branchCnt != 32'hFFFF_FFFF)) begin
                branchCnt <= branchCnt + 32'd1;
            end
            if (mispredictE && (mispredictCnt != 32'hFFFF_FFFF)) begin
                mispredictCnt <= mispredictCnt + 32'd1;
            end
        end
    end

    assign branchCount     = branchCnt;
    assign mispredictCount = mispredictCnt;
`else
    assign branchCount     = '0;
    assign mispredictCount = '0;
`endif

endmodule

// File: doc/branch_history_tracker.md
Name: branch_history_tracker

Overview:
- Producer and feedback side of the pattern history table interface.
- Keeps a speculative global history register (GHR) and forms the gshare lookup index from the fetch PC and the GHR.
- Carries each predicted branch's index, prediction and history checkpoint through the Decode and Execute pipeline registers.
- In Execute, reports the prediction, the update index and the misprediction to the PHT and hazard logic, and repairs the GHR after a misprediction.

Parameters:
- INDEX_W, 3, PHT index width (PHT has 2^INDEX_W entries).
- HIST_W, 3, GHR width; must satisfy 2 <= HIST_W <= INDEX_W.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pcF  in  PC_W  fetch-stage PC
- branchF  in  1  fetched instruction is a branch and is being predicted
- predictionF  in  1  PHT prediction for the fetch index (1 = taken)
- stallF  in  1  fetch stall
- stallD  in  1  decode stall
- flushD  in  1  decode flush
- flushE  in  1  execute flush (bubble insert)
- branchE  in  1  branch in Execute is resolving this cycle
- branchTakenE  in  1  actual branch outcome
- PHTinpId  out  INDEX_W  lookup index to PHT
- PHTupdId  out  INDEX_W  index of the resolving branch
- branchPredictedE  out  1  prediction carried with the Execute branch
- mispredictE  out  1  resolving branch was mispredicted
- ghrOut  out  HIST_W  current speculative GHR
- branchCount  out  32  resolved branch count (optional feature)
- mispredictCount  out  32  misprediction count (optional feature)

Behaviour:
- Lookup index (combinational): PHTinpId = pcF[INDEX_W+1:2] XOR zero-extended ghr.
- Fetch capture (fetchAcc = branchF && !stallF && !mispredictE):
  - ghr <= {ghr[HIST_W-2:0], predictionF}.
  - D registers load validD=1, idxD=PHTinpId, predD=predictionF, ckptD=ghr (pre-shift value).
- D register update, in priority order:
  - mispredictE or flushD: validD <= 0.
  - else stallD: hold.
  - else if !stallF: load from fetch; validD = fetchAcc.
- E register update, in priority order:
  - mispredictE or flushE: validE <= 0.
  - else: load validE/idxE/predE/ckptE from D.
- Resolution, when resolveE = validE && branchE:
  - branchPredictedE = predE; PHTupdId = idxE.
  - mispredictE = resolveE && (branchTakenE != predE).
  - Otherwise branchPredictedE = 0, mispredictE = 0, and PHTupdId = idxE (don't care).
  - branchE with validE = 0 is ignored: no output and no state change.
- Repair: on mispredictE, next cycle ghr <= {ckptE[HIST_W-2:0], branchTakenE}.
  - Repair has priority over a same-cycle fetch shift; that fetched branch is wrong-path and is not captured.
- Correct prediction: no GHR change, since the speculative bit is already correct.
- Latency:
  - Fetch to Execute is 2 cycles when there are no stalls.
  - mispredictE is combinational in the resolve cycle.
  - The repaired GHR is visible one cycle later.
- Reset, including mid-operation, clears on the next edge:
  - ghr = 0, validD = validE = 0, all idx/pred/ckpt registers = 0.
  - Hence mispredictE = 0, branchPredictedE = 0, ghrOut = 0, PHTinpId = pcF[INDEX_W+1:2].
- GHR wraps by shifting only; the oldest bit is discarded.

Optional Feature:
- Macro: BHT_PERF_CNT_EN.
- Defined:
  - branchCount increments on each resolveE.
  - mispredictCount increments on each mispredictE.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are present and tied to 0; no counter logic is synthesized.

Test Plan:
1. Reset, pcF=0x14, branchF=0 -> PHTinpId=5, ghrOut=0, mispredictE=0, branchPredictedE=0.
2. pcF=0x14, branchF=1, predictionF=1, no stalls -> next cycle ghrOut=1; with pcF=0x14 still applied, PHTinpId=4.
3. Branch from test 2 reaches Execute 2 cycles later, branchE=1, branchTakenE=0 -> mispredictE=1, branchPredictedE=1, PHTupdId=5; next cycle ghrOut=0 and validD/validE=0.
4. Predicted 0 at pcF=0x8 (index 2), resolves with branchTakenE=0 -> mispredictE=0, PHTupdId=2, GHR holds speculative value 0.
5. Mispredict in E (ckpt=3'b011, taken=1) with branchF=1, predictionF=1 in the same cycle -> ghrOut=3'b111; the fetched branch never reaches E.
6. Branch held by stallD for 3 cycles, then released -> resolves 3 cycles late with the original idx/pred. Separately, reset asserted while a branch is in D -> validD/validE=0, ghrOut=0, no mispredictE. With BHT_PERF_CNT_EN defined, after tests 3 and 4: branchCount=2, mispredictCount=1.
